display_scan_controller: RTL and testbench

//  Scans the read half of the double-buffered display memory and drives a single-line LED panel.

---
 rtl/display_scan_controller_if.sv | 39 +++
 rtl/display_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_display_scan_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_if.sv
// Bundle of the scan controller's external signals: run control, buffer-swap handshake,
// display-memory read port and the LED panel connector.
//   master : the scan controller (drives memory address, flip, swap_ack and panel pins)
//   slave  : the environment (drives enable, swap_req and memory read data)
interface display_scan_controller_if #(
  parameter int unsigned rows    = 8,
  parameter int unsigned columns = 32,
  parameter int unsigned width   = 24
);
  localparam int unsigned RowW = $clog2(rows);
  localparam int unsigned ColW = $clog2(columns);

  logic              enable;
  logic              swap_req;
  logic              swap_ack;
  logic              flip;
  logic [RowW-1:0]   orow;
  logic [ColW-1:0]   ocol;
  logic [width-1:0]  mem_o;
  logic              panel_r;
  logic              panel_g;
  logic              panel_b;
  logic              panel_clk;
  logic              panel_lat;
  logic              panel_oe_n;
  logic [RowW-1:0]   panel_addr;

  modport master (
    input  enable, swap_req, mem_o,
    output swap_ack, flip, orow, ocol,
    output panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe_n, panel_addr
  );

  modport slave (
    output enable, swap_req, mem_o,
    input  swap_ack, flip, orow, ocol,
    input  panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe_n, panel_addr
  );
endinterface

// File: rtl/display_scan_controller.sv
// Scans the read half of a double-buffered display memory and drives a single-line LED panel
// using binary-coded modulation over per-colour bit planes. Owns the memory flip select and
// swaps buffers only at a frame boundary (or while idle), so no torn frame is ever shown.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   bus       : display_scan_controller_if.master
//               enable/swap_req/swap_ack, flip/orow/ocol/mem_o (memory),
//               panel_r/g/b, panel_clk, panel_lat, panel_oe_n, panel_addr (panel)
// All bus outputs are registered.
module display_scan_controller #(
  parameter int unsigned rows    = 8,
  parameter int unsigned columns = 32,
  parameter int unsigned width   = 24,
  parameter int unsigned bpc     = 8,
  parameter int unsigned oe_base = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  display_scan_controller_if.master  bus
);

  localparam int unsigned RowW    = $clog2(rows);
  localparam int unsigned ColW    = $clog2(columns);
  localparam int unsigned PlaneW  = $clog2(bpc);
  localparam int unsigned SlotW   = $clog2(columns + 1);
  localparam int unsigned DispMax = oe_base << (bpc - 1);
  localparam int unsigned DispW   = $clog2(DispMax + 1);

  typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

  state_e             state_q;
  logic [RowW-1:0]    row_q;
  logic [PlaneW-1:0]  plane_q;
  logic [SlotW-1:0]   slot_q;     // 0..columns; the extra slot flushes the last column
  logic               phase_q;    // 0 = first clk of a slot, 1 = second
  logic [ColW-1:0]    ocol_q;
  logic [RowW-1:0]    orow_q;
  logic [DispW-1:0]   dcnt_q;
  logic               flip_q;
  logic               ack_q;
  logic               req_seen_q; // request already honoured; wait for it to drop
  logic               pr_q, pg_q, pb_q;
  logic               pclk_q, lat_q, oe_n_q;
  logic [RowW-1:0]    addr_q;

  logic [bpc-1:0]     r_bits, g_bits, b_bits;
  logic               plane_last, row_last, swap_ok;
  logic [PlaneW-1:0]  plane_nxt;
  logic [RowW-1:0]    row_nxt;

  assign r_bits = bus.mem_o[2*bpc +: bpc];
  assign g_bits = bus.mem_o[bpc +: bpc];
  assign b_bits = bus.mem_o[0 +: bpc];

  always_comb begin
    plane_last = (plane_q == PlaneW'(bpc - 1));
    row_last   = (row_q == RowW'(rows - 1));
    plane_nxt  = plane_last ? '0 : plane_q + 1'b1;
    row_nxt    = row_q;
    if (plane_last) begin
      row_nxt = row_last ? '0 : row_q + 1'b1;
    end
    swap_ok = bus.swap_req && !req_seen_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      plane_q    <= '0;
      slot_q     <= '0;
      phase_q    <= 1'b0;
      ocol_q     <= '0;
      orow_q     <= '0;
      dcnt_q     <= '0;
      flip_q     <= 1'b0;
      ack_q      <= 1'b0;
      req_seen_q <= 1'b0;
      pr_q       <= 1'b0;
      pg_q       <= 1'b0;
      pb_q       <= 1'b0;
      pclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      addr_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      if (!bus.swap_req) begin
        req_seen_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          oe_n_q <= 1'b1;
          if (swap_ok) begin
            flip_q     <= ~flip_q;
            ack_q      <= 1'b1;
            req_seen_q <= 1'b1;
          end
          if (bus.enable) begin
            state_q <= StShift;
            row_q   <= '0;
            plane_q <= '0;
            orow_q  <= '0;
            slot_q  <= '0;
            phase_q <= 1'b0;
            ocol_q  <= '0;
            pclk_q  <= 1'b0;
          end
        end

        StShift: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            // mem_o now holds the previous slot's column regardless of memory read phase
            if (slot_q != '0) begin
              pclk_q <= 1'b1;
              pr_q   <= r_bits[plane_q];
              pg_q   <= g_bits[plane_q];
              pb_q   <= b_bits[plane_q];
            end
          end else begin
            phase_q <= 1'b0;
            pclk_q  <= 1'b0;
            if (slot_q == SlotW'(columns)) begin
              state_q <= StBlank;
            end else begin
              slot_q <= slot_q + 1'b1;
              if (slot_q < SlotW'(columns - 1)) begin
                ocol_q <= ocol_q + 1'b1;
              end
            end
          end
        end

        StBlank: begin
          addr_q  <= row_q;
          lat_q   <= 1'b1;
          state_q <= StLatch;
        end

        StLatch: begin
          lat_q   <= 1'b0;
          oe_n_q  <= 1'b0;
          dcnt_q  <= DispW'((oe_base << plane_q) - 1);
          state_q <= StDisplay;
        end

        StDisplay: begin
          if (dcnt_q == '0) begin
            oe_n_q <= 1'b1;
            if (plane_last && row_last && swap_ok) begin
              flip_q     <= ~flip_q;
              ack_q      <= 1'b1;
              req_seen_q <= 1'b1;
            end
            if (!bus.enable) begin
              state_q <= StIdle;
              row_q   <= '0;
              plane_q <= '0;
            end else begin
              state_q <= StShift;
              row_q   <= row_nxt;
              plane_q <= plane_nxt;
              orow_q  <= row_nxt;
              slot_q  <= '0;
              phase_q <= 1'b0;
              ocol_q  <= '0;
            end
          end else begin
            dcnt_q <= dcnt_q - 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.swap_ack   = ack_q;
  assign bus.flip       = flip_q;
  assign bus.orow       = orow_q;
  assign bus.ocol       = ocol_q;
  assign bus.panel_r    = pr_q;
  assign bus.panel_g    = pg_q;
  assign bus.panel_b    = pb_q;
  assign bus.panel_clk  = pclk_q;
  assign bus.panel_lat  = lat_q;
  assign bus.panel_oe_n = oe_n_q;
  assign bus.panel_addr = addr_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: reset, shift data/timing, BCM plane timing over a
// full frame, frame-end and idle buffer swaps, enable drop mid-frame and restart.
module tb_display_scan_controller;

  localparam int unsigned Rows   = 8;
  localparam int unsigned Cols   = 32;
  localparam int unsigned Width  = 24;
  localparam int unsigned Bpc    = 8;
  localparam int unsigned OeBase = 4;
  localparam int          Frame  = 12512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_controller_if #(.rows(Rows), .columns(Cols), .width(Width)) bus ();

  display_scan_controller #(
    .rows(Rows), .columns(Cols), .width(Width), .bpc(Bpc), .oe_base(OeBase)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Half 1 holds pixel = column in every colour; half 0 holds its complement.
  function automatic logic [23:0] pix(input logic half, input int c);
    logic [7:0] v;
    v = c[7:0];
    return half ? {v, v, v} : {~v, ~v, ~v};
  endfunction

  // Memory reads once per 2 clks; mem_ph picks which edge. Reads the half selected by !flip.
  logic mem_tgl = 1'b0;
  logic mem_ph  = 1'b0;
  always @(posedge clk) begin
    mem_tgl <= ~mem_tgl;
    if (mem_tgl == mem_ph) bus.mem_o <= pix(~bus.flip, int'(bus.ocol));
  end

  // Output-enable low runs: length and row address of each.
  int run_len[80];
  int run_addr[80];
  int nruns, cur_len, cur_addr;

  task automatic track_runs();
    if (bus.panel_oe_n == 1'b0) begin
      cur_len++;
      cur_addr = int'(bus.panel_addr);
    end else if (cur_len > 0) begin
      if (nruns < 80) begin
        run_len[nruns]  = cur_len;
        run_addr[nruns] = cur_addr;
      end
      nruns++;
      cur_len = 0;
    end
  endtask

  initial begin
    logic [31:0] r0, g0, b0, r1;
    int nr0, nr1, lat_t, nlat, nack, ack_t, run_err, post_act, acts, toggles, first_oe;
    logic pclk_prev, flip_prev, found;

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.swap_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe_n", bus.panel_oe_n, 1);
    check("rst_flip", bus.flip, 0);
    check("rst_lat", bus.panel_lat, 0);
    check("rst_pclk", bus.panel_clk, 0);
    check("rst_ack", bus.swap_ack, 0);
    check("rst_addr_orow_ocol", {bus.panel_addr, bus.orow, bus.ocol}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_oe_n", bus.panel_oe_n, 1);

    // ---- Shift, BCM timing and frame-end swap over one full frame plus a bit ----
    mem_ph = 1'b0;
    bus.enable = 1'b1;
    r0 = '0; g0 = '0; b0 = '0; r1 = '0;
    nr0 = 0; nr1 = 0; lat_t = -1; nlat = 0; nack = 0; ack_t = -1;
    nruns = 0; cur_len = 0; cur_addr = 0; pclk_prev = 1'b0;
    for (int t = 0; t < Frame + 88; t++) begin
      @(negedge clk);
      if (t == 0) check("start_orow_ocol", {bus.orow, bus.ocol}, 0);
      if (t == 100) bus.swap_req = 1'b1;
      if (t == Frame - 1) check("flip_before_frame_end", bus.flip, 0);
      if (t == Frame) check("flip_at_frame_end", bus.flip, 1);
      if (bus.swap_ack) begin
        nack++;
        ack_t = t;
        bus.swap_req = 1'b0;
      end
      if (bus.panel_clk && !pclk_prev) begin
        if (t < 66) begin
          if (nr0 < 32) begin
            r0[nr0] = bus.panel_r; g0[nr0] = bus.panel_g; b0[nr0] = bus.panel_b;
          end
          nr0++;
        end else if (t >= Frame && t < Frame + 66) begin
          if (nr1 < 32) r1[nr1] = bus.panel_r;
          nr1++;
        end
      end
      if (bus.panel_lat && t < 100) begin
        if (lat_t < 0) lat_t = t;
        nlat++;
      end
      track_runs();
      pclk_prev = bus.panel_clk;
    end
    check("shift_rises", nr0, 32);
    check("shift_r_bits", r0, 32'hAAAA_AAAA);
    check("shift_g_bits", g0, 32'hAAAA_AAAA);
    check("shift_b_bits", b0, 32'hAAAA_AAAA);
    check("lat_clk", lat_t, 67);
    check("lat_width", nlat, 1);
    check("bcm_runs", nruns, 65);
    run_err = 0;
    for (int i = 0; i < 65; i++) begin
      if (run_len[i] != (4 << (i % 8)) || run_addr[i] != ((i / 8) % 8)) run_err++;
    end
    check("bcm_run_errors", run_err, 0);
    check("bcm_plane0_len", run_len[0], 4);
    check("bcm_plane7_len", run_len[7], 512);
    check("bcm_last_row_addr", run_addr[63], 7);
    check("bcm_wrap_addr", run_addr[64], 0);
    check("swap_ack_count", nack, 1);
    check("swap_ack_clk", ack_t, Frame);
    check("new_buf_rises", nr1, 32);
    check("new_buf_r_bits", r1, 32'h5555_5555);

    // ---- Reset asserted mid-DISPLAY ----
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!bus.panel_oe_n) found = 1'b1;
    end
    check("wait_display", found, 1);
    bus.enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_oe_n", bus.panel_oe_n, 1);
    check("midrst_flip", bus.flip, 0);
    check("midrst_lat_clk_ack", {bus.panel_lat, bus.panel_clk, bus.swap_ack}, 0);
    @(negedge clk);
    rst = 1'b0;
    acts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.panel_oe_n || bus.panel_clk || bus.panel_lat) acts++;
    end
    check("idle_after_rst", acts, 0);

    // ---- Swap while idle, request held 3 clks ----
    bus.swap_req = 1'b1;
    nack = 0; toggles = 0; flip_prev = bus.flip;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("idle_swap_first", {bus.flip, bus.swap_ack}, 2'b11);
      if (i == 2) bus.swap_req = 1'b0;
      if (bus.swap_ack) nack++;
      if (bus.flip != flip_prev) toggles++;
      flip_prev = bus.flip;
    end
    check("idle_swap_acks", nack, 1);
    check("idle_swap_toggles", toggles, 1);
    check("idle_swap_flip", bus.flip, 1);

    // ---- Enable drop during row 3 plane 2 SHIFT, other memory phase ----
    mem_ph = 1'b1;
    bus.enable = 1'b1;
    nruns = 0; cur_len = 0; post_act = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (t == 4860) bus.enable = 1'b0;
      if (t >= 4924 && (!bus.panel_oe_n || bus.panel_clk || bus.panel_lat)) post_act++;
      track_runs();
    end
    check("drop_runs", nruns, 27);
    check("drop_last_len", run_len[26], 16);
    check("drop_last_addr", run_addr[26], 3);
    check("drop_idle_quiet", post_act, 0);

    // ---- Re-enable restarts at row 0 plane 0 ----
    bus.enable = 1'b1;
    first_oe = -1; acts = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (t == 0) check("restart_orow", bus.orow, 0);
      if (!bus.panel_oe_n) begin
        acts++;
        if (first_oe < 0) begin
          first_oe = t;
          check("restart_addr", bus.panel_addr, 0);
        end
      end
    end
    check("restart_oe_start", first_oe, 68);
    check("restart_oe_len", acts, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
